// File: rtl/unified_mem_port_if.sv
// Bus bundle between the core's fetch/data stages and the shared memory port.
// The core drives requests (master); the memory port drives grants and read data (slave).
interface unified_mem_port_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [DATA_W-1:0]     i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W/8-1:0]   d_be;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_be, d_wdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_be, d_wdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata
    );
endinterface

// File: rtl/unified_mem_port.sv
// Single-ported RAM shared by an instruction-fetch port and a data port, one access per cycle.
// Define MEM_ARB_RR_EN for round-robin arbitration on contention; default is data-over-instruction priority.
module unified_mem_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    unified_mem_port_if.slave bus
);
    localparam int BYTES    = DATA_W / 8;
    localparam int WORD_LSB = $clog2(BYTES);
    localparam int IDX_W    = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [IDX_W-1:0]  i_idx_s;
    logic [IDX_W-1:0]  d_idx_s;
    logic [IDX_W-1:0]  acc_idx_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              i_gnt_s;
    logic              d_gnt_s;
    logic              d_rd_s;
    logic              wr_en_s;

    logic              i_rvalid_r;
    logic              d_rvalid_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;

    // Byte offset is dropped and the word index wraps modulo DEPTH.
    assign i_idx_s = IDX_W'(bus.i_addr >> WORD_LSB);
    assign d_idx_s = IDX_W'(bus.d_addr >> WORD_LSB);

`ifdef MEM_ARB_RR_EN
    typedef enum logic {
        WIN_INSTR = 1'b0,
        WIN_DATA  = 1'b1
    } winner_e;

    winner_e last_winner_r;
    winner_e last_winner_nxt_s;

    // Remember who won the most recent contended cycle.
    always_comb begin
        last_winner_nxt_s = last_winner_r;
        if (bus.i_req && bus.d_req) begin
            last_winner_nxt_s = d_gnt_s ? WIN_DATA : WIN_INSTR;
        end else begin
            last_winner_nxt_s = last_winner_r;
        end
    end

    // Last-winner state register; starts on instruction so data takes the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_winner_r <= WIN_INSTR;
        end else begin
            last_winner_r <= last_winner_nxt_s;
        end
    end
`endif

    // Single-grant arbiter; grants are combinational in the request cycle.
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        case ({bus.i_req, bus.d_req})
            2'b01: d_gnt_s = 1'b1;
            2'b10: i_gnt_s = 1'b1;
            2'b11: begin
`ifdef MEM_ARB_RR_EN
                if (last_winner_r == WIN_DATA) begin
                    i_gnt_s = 1'b1;
                end else begin
                    d_gnt_s = 1'b1;
                end
`else
                d_gnt_s = 1'b1;
`endif
            end
            default: begin
                i_gnt_s = 1'b0;
                d_gnt_s = 1'b0;
            end
        endcase
    end

    // One physical array port: the granted requester owns the address.
    always_comb begin
        acc_idx_s = i_idx_s;
        if (d_gnt_s) begin
            acc_idx_s = d_idx_s;
        end else begin
            acc_idx_s = i_idx_s;
        end
    end

    assign rd_word_s = mem_r[acc_idx_s];
    assign d_rd_s    = d_gnt_s & ~bus.d_we;
    assign wr_en_s   = d_gnt_s & bus.d_we & reset;

    // Byte-masked array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int k = 0; k < BYTES; k++) begin
                if (bus.d_be[k]) begin
                    mem_r[d_idx_s][8*k +: 8] <= bus.d_wdata[8*k +: 8];
                end
            end
        end
    end

    // Read return registers; rdata holds until the next granted read on its port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            i_rdata_r  <= {DATA_W{1'b0}};
            d_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            i_rvalid_r <= i_gnt_s;
            d_rvalid_r <= d_rd_s;
            if (i_gnt_s) begin
                i_rdata_r <= rd_word_s;
            end
            if (d_rd_s) begin
                d_rdata_r <= rd_word_s;
            end
        end
    end

    assign bus.i_gnt    = i_gnt_s;
    assign bus.d_gnt    = d_gnt_s;
    assign bus.i_rvalid = i_rvalid_r;
    assign bus.d_rvalid = d_rvalid_r;
    assign bus.i_rdata  = i_rdata_r;
    assign bus.d_rdata  = d_rdata_r;
endmodule

// File: tb/tb_unified_mem_port.sv
// Bench for unified_mem_port: directed literal scenarios followed by randomized traffic
// checked every cycle against a word/byte-level memory model.
module tb_unified_mem_port;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 1024;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    unified_mem_port_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    unified_mem_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_mem   [DEPTH] = '{default: 32'h0};
    logic [3:0]  m_known [DEPTH] = '{default: 4'h0};
    logic        m_last_d = 1'b0;
    logic        exp_iv = 1'b0;
    logic        exp_dv = 1'b0;
    logic [31:0] exp_ird = 32'h0;
    logic [31:0] exp_drd = 32'h0;
    logic [31:0] exp_im = 32'hFFFF_FFFF;
    logic [31:0] exp_dm = 32'hFFFF_FFFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic gnt_d(input logic ir, input logic dr, input logic last_was_d);
`ifdef MEM_ARB_RR_EN
        return dr && (!ir || !last_was_d);
`else
        return dr;
`endif
    endfunction

    function automatic logic gnt_i(input logic ir, input logic dr, input logic last_was_d);
        return ir && !gnt_d(ir, dr, last_was_d);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 32'd1024);
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] kn);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{kn[k]}};
        return m;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[11:2] = 10'($urandom_range(0, 15));
        return a;
    endfunction

    // Model update on each clock edge; asynchronous reset clears the read-side expectations.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_last_d <= 1'b0;
            exp_iv   <= 1'b0;
            exp_dv   <= 1'b0;
            exp_ird  <= 32'h0;
            exp_drd  <= 32'h0;
            exp_im   <= 32'hFFFF_FFFF;
            exp_dm   <= 32'hFFFF_FFFF;
        end else begin
            if (bus.i_req && bus.d_req) m_last_d <= gnt_d(1'b1, 1'b1, m_last_d);
            exp_iv <= gnt_i(bus.i_req, bus.d_req, m_last_d);
            exp_dv <= gnt_d(bus.i_req, bus.d_req, m_last_d) && !bus.d_we;
            if (gnt_i(bus.i_req, bus.d_req, m_last_d)) begin
                exp_ird <= m_mem[widx(bus.i_addr)];
                exp_im  <= bmask(m_known[widx(bus.i_addr)]);
            end
            if (gnt_d(bus.i_req, bus.d_req, m_last_d) && !bus.d_we) begin
                exp_drd <= m_mem[widx(bus.d_addr)];
                exp_dm  <= bmask(m_known[widx(bus.d_addr)]);
            end
            if (gnt_d(bus.i_req, bus.d_req, m_last_d) && bus.d_we) begin
                for (int k = 0; k < 4; k++) begin
                    if (bus.d_be[k]) begin
                        m_mem[widx(bus.d_addr)][8*k +: 8] <= bus.d_wdata[8*k +: 8];
                        m_known[widx(bus.d_addr)][k]      <= 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        chk("i_gnt", 32'(bus.i_gnt), 32'(gnt_i(bus.i_req, bus.d_req, m_last_d)));
        chk("d_gnt", 32'(bus.d_gnt), 32'(gnt_d(bus.i_req, bus.d_req, m_last_d)));
        chk("one_gnt", 32'(bus.i_gnt & bus.d_gnt), 32'd0);
        chk("i_rvalid", 32'(bus.i_rvalid), 32'(exp_iv));
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(exp_dv));
        chk("i_rdata", bus.i_rdata & exp_im, exp_ird & exp_im);
        chk("d_rdata", bus.d_rdata & exp_dm, exp_drd & exp_dm);
    end

    task automatic op(input bit is_i, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd);
        if (is_i) begin
            bus.i_req  = 1'b1;
            bus.i_addr = addr;
        end else begin
            bus.d_req   = 1'b1;
            bus.d_we    = we;
            bus.d_addr  = addr;
            bus.d_be    = be;
            bus.d_wdata = wd;
        end
        @(negedge clk);
        if (is_i) chk("dir_i_gnt", 32'(bus.i_gnt), 32'd1);
        else      chk("dir_d_gnt", 32'(bus.d_gnt), 32'd1);
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
    endtask

    task automatic rd_expect(input bit is_i, input logic [31:0] exp);
        @(negedge clk);
        if (is_i) begin
            chk("dir_i_rvalid", 32'(bus.i_rvalid), 32'd1);
            chk("dir_i_rdata", bus.i_rdata, exp);
        end else begin
            chk("dir_d_rvalid", 32'(bus.d_rvalid), 32'd1);
            chk("dir_d_rdata", bus.d_rdata, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr_expect();
        @(negedge clk);
        chk("dir_wr_no_rvalid", 32'(bus.d_rvalid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] gi;
        logic [3:0] gd;
        logic       ig;
        logic       dg;
        bus.i_req = 1'b0; bus.i_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0;
        bus.d_be = 4'h0;  bus.d_wdata = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_i_rvalid", 32'(bus.i_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        chk("rst_i_rdata", bus.i_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        op(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        wr_expect();
        op(1'b0, 1'b0, 32'h10, 4'h0, 32'h0);
        rd_expect(1'b0, 32'hDEAD_BEEF);
        op(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        rd_expect(1'b1, 32'hDEAD_BEEF);

        op(1'b0, 1'b1, 32'h10, 4'b0101, 32'h1122_3344);
        wr_expect();
        op(1'b0, 1'b0, 32'h10, 4'h0, 32'h0);
        rd_expect(1'b0, 32'hDE22_BE44);

        // Contention: both ports reading for four cycles
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            gi[c] = bus.i_gnt;
            gd[c] = bus.d_gnt;
            @(posedge clk);
            #1;
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
`ifdef MEM_ARB_RR_EN
        chk("cont_d_gnt", 32'(gd), 32'h5);
        chk("cont_i_gnt", 32'(gi), 32'hA);
`else
        chk("cont_d_gnt", 32'(gd), 32'hF);
        chk("cont_i_gnt", 32'(gi), 32'h0);
`endif

        op(1'b0, 1'b1, 32'h0, 4'hF, 32'hA5A5_A5A5);
        wr_expect();
        op(1'b0, 1'b0, 32'h1000, 4'h0, 32'h0);
        rd_expect(1'b0, 32'hA5A5_A5A5);
        op(1'b0, 1'b0, 32'h3, 4'h0, 32'h0);
        rd_expect(1'b0, 32'hA5A5_A5A5);

        // Asynchronous reset right after an instruction read is granted
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        @(negedge clk);
        chk("ar_i_gnt", 32'(bus.i_gnt), 32'd1);
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("ar_i_rvalid", 32'(bus.i_rvalid), 32'd0);
        chk("ar_i_rdata", bus.i_rdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        op(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        rd_expect(1'b1, 32'hDE22_BE44);

        // Randomized traffic; an ungranted request is held unchanged
        ig = 1'b0;
        dg = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!bus.i_req || ig) begin
                bus.i_req  = ($urandom_range(0, 3) != 0);
                bus.i_addr = rand_addr();
            end
            if (!bus.d_req || dg) begin
                bus.d_req   = ($urandom_range(0, 3) != 0);
                bus.d_we    = ($urandom_range(0, 1) != 0);
                bus.d_addr  = rand_addr();
                bus.d_be    = 4'($urandom_range(0, 15));
                bus.d_wdata = $urandom;
            end
            @(negedge clk);
            ig = bus.i_gnt;
            dg = bus.d_gnt;
            @(posedge clk);
            #1;
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/unified_mem_port.md
# unified_mem_port

Single-ported shared memory with a two-channel front end: an instruction-fetch port (read-only) and a data port (read/write with byte enables) arbitrate for one synchronous RAM of parametrised width and depth. It replaces the split instruction/data memory pair beside the pipelined core when the memory is a single physical array. Grants are issued in the request cycle and read data returns one cycle later. The core stalls the losing stage on a missing grant.

## Interface
- DATA_W, 32: word width in bits; multiple of 8, at least 16.
- ADDR_W, 32: byte-address width of both ports.
- DEPTH, 1024: words in the array; power of 2.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction read request.
- i_addr  in  ADDR_W  instruction byte address.
- i_gnt  out  1  instruction request accepted this cycle (combinational).
- i_rvalid  out  1  i_rdata valid (registered).
- i_rdata  out  DATA_W  instruction word (registered).
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data byte address.
- d_be  in  DATA_W/8  byte enables, write only; bit k covers bits 8k+7:8k.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  d_rdata valid; pulses for granted reads only (registered).
- d_rdata  out  DATA_W  data read word (registered).

## Operation
- Word index = (addr >> log2(DATA_W/8)) mod DEPTH. Low byte-offset bits are ignored. Out-of-range addresses wrap; no error.
- At most one access per cycle, so i_gnt & d_gnt is never 1.
- Only one requester active: it is granted.
- Both requesting, default (fixed priority): data wins; i_gnt=0.
- Both requesting, with MEM_ARB_RR_EN: the port not granted last contended cycle wins. The last_winner register updates only on cycles where both requested.
- Requester obligations:
  - A requester holds its request and fields stable until granted.
  - The block does not latch ungranted requests.
- Granted write:
  - Bytes with d_be[k]=1 are updated at the clock edge.
  - d_be=0 is a legal no-op write.
  - No d_rvalid pulse.
- Granted read:
  - Next cycle, the *_rvalid for that port is 1 and *_rdata = array word.
  - *_rdata holds its value until the next granted read on that port.
- Read of a word written in an earlier cycle returns the new value. A same-cycle read/write collision cannot occur because of single grant.
- Array contents are not reset and are undefined until written, unless the simulation preloads them.

## Timing
- Reset values:
  - i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0.
  - last_winner = instruction, so the first contended RR cycle goes to data.
  - Grants follow inputs combinationally even during reset but have no effect while reset=0.
- Read latency is 1 cycle, grant to rvalid. Throughput is 1 access/cycle total.
- Reset mid-operation:
  - rvalid clears immediately (asynchronous).
  - A read granted in the reset-release cycle returns normally.
  - A write in progress on the asserting edge may or may not land. Software must not rely on it.
- Back-to-back reads on one port: rvalid stays high, and rdata changes each cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration on contention, with the last_winner flop present. Each port wins at least every second contended cycle.
- MEM_ARB_RR_EN undefined: fixed data-over-instruction priority; no last_winner flop. The instruction port may starve while d_req is held high.

## Test plan
- Reset, then write-read, write step: reset low 3 cycles, outputs all 0. Single d write, addr 0x10, be 4'hF, wdata 0xDEADBEEF -> d_gnt=1, no d_rvalid.
- Reset, then write-read, read step: d read at 0x10 -> d_gnt=1. Next cycle d_rvalid=1, d_rdata=0xDEADBEEF. i read at 0x10 returns the same on i_rdata.
- Byte enables: after 0xDEADBEEF at 0x10, write be=4'b0101, wdata 0x11223344 -> read returns 0xDE22BE44.
- Contention:
  - i_req and d_req high for 4 cycles.
  - Without macro: d_gnt=1 all 4 cycles, i_gnt=0.
  - With MEM_ARB_RR_EN: grants go D,I,D,I.
- Wrap and offset, DEPTH=1024, DATA_W=32: write 0xA5A5A5A5 at addr 0x0 -> read at 0x1000 and at 0x3 both return 0xA5A5A5A5.
- Async reset mid-read: grant i read, assert reset 2 ns after the edge -> i_rvalid drops to 0 before the next edge. After release, i read at 0x10 returns the stored word one cycle after grant.
